// File: rtl/memory_pkg.sv
// memory_pkg: shared L1 D-cache types for the d1 write-back buffer
// Provides WBB depth/width constants, the free-entry count type, entry state enum and entry record.
package memory_pkg;
  localparam int WBB_N_ENTRIES = 4;
  localparam int WBB_LINE_ADDR_W = 58;
  localparam int WBB_LINE_W = 512;
  typedef logic [$clog2(WBB_N_ENTRIES+1)-1:0] wbb_free_entries_t;
  typedef enum logic [1:0] {WBB_FREE, WBB_VALID, WBB_SENT} wbb_entry_state_e;
  typedef struct packed {
    wbb_entry_state_e state;
    logic [WBB_LINE_ADDR_W-1:0] addr;
    logic [WBB_LINE_W-1:0] line;
  } wbb_entry_t;
endpackage

// File: rtl/d1_wbb_fwd_lookup.sv
// d1_wbb_fwd_lookup: N-way address compare, youngest match relative to tail wins
// Ports: en_i (entry occupied mask), addr_i (entry addresses), lookup_addr_i, tail_i (next alloc slot),
//        hit_o (any enabled match), idx_o (index of the youngest matching entry).
module d1_wbb_fwd_lookup #(
  parameter int N = 4,
  parameter int AW = 58,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  en_i,
  input  logic [AW-1:0] addr_i [N],
  input  logic [AW-1:0] lookup_addr_i,
  input  logic [PW-1:0] tail_i,
  output logic          hit_o,
  output logic [PW-1:0] idx_o
);
  logic [PW-1:0] idx;
  // Walk from oldest (tail-N) to youngest (tail-1); the last match seen is the youngest.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      idx = tail_i - PW'(k);
      if (en_i[idx] && addr_i[idx] == lookup_addr_i) begin
        hit_o = 1'b1;
        idx_o = idx;
      end
    end
  end
endmodule

// File: rtl/d1_wb_buffer.sv
// d1_wb_buffer: L1 D-cache write-back buffer holding dirty evictions until L2 acks the write
// Ports: clk_i/rst_ni (async active-low); evict_* push interface; d0_lookup_* / wbb_d0_fwd_o / d0_fwd_line_o
//        forwarding; wbb_l2c_req_* oldest unsent request, wbb_l2c_transaction_ok_i accept, l2c_wbb_wr_ack_i
//        in-order write ack; wbb_free_entries_o, wbb_empty_o occupancy status.
// Option: define D1_WBB_COALESCE_EN to merge a push into a matching not-yet-sent entry.
module d1_wb_buffer import memory_pkg::*; #(
  parameter int N_ENTRIES = WBB_N_ENTRIES,
  parameter int LINE_ADDR_W = WBB_LINE_ADDR_W,
  parameter int LINE_W = WBB_LINE_W
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   evict_valid_i,
  input  logic [LINE_ADDR_W-1:0] evict_addr_i,
  input  logic [LINE_W-1:0]      evict_line_i,
  output logic                   evict_rdy_o,
  input  logic                   d0_lookup_valid_i,
  input  logic [LINE_ADDR_W-1:0] d0_lookup_addr_i,
  output logic                   wbb_d0_fwd_o,
  output logic [LINE_W-1:0]      d0_fwd_line_o,
  output logic                   wbb_l2c_req_valid_o,
  output logic [LINE_ADDR_W-1:0] wbb_l2c_req_addr_o,
  output logic [LINE_W-1:0]      wbb_l2c_req_line_o,
  input  logic                   wbb_l2c_transaction_ok_i,
  input  logic                   l2c_wbb_wr_ack_i,
  output wbb_free_entries_t      wbb_free_entries_o,
  output logic                   wbb_empty_o
);
  localparam int PW = $clog2(N_ENTRIES);
  localparam int CW = $clog2(N_ENTRIES+1);
  logic [PW-1:0] tail_q, tail_d, send_q, send_d, ack_q, ack_d;
  logic [CW-1:0] occ_q, occ_d, unsent_q, unsent_d;
  wbb_entry_state_e state_q [N_ENTRIES];
  wbb_entry_state_e state_d [N_ENTRIES];
  logic [LINE_ADDR_W-1:0] addr_q [N_ENTRIES];
  logic [LINE_W-1:0] line_q [N_ENTRIES];
  logic [N_ENTRIES-1:0] busy;
  logic full, push, alloc, tx, ack, coal_hit, fwd_hit;
  logic [PW-1:0] coal_idx, wr_idx, fwd_idx;
  assign full = occ_q == CW'(N_ENTRIES);
  assign tx = wbb_l2c_transaction_ok_i && unsent_q != '0;
  // A sent entry exists exactly when occupancy exceeds the unsent count.
  assign ack = l2c_wbb_wr_ack_i && occ_q != unsent_q;
`ifdef D1_WBB_COALESCE_EN
  // The entry leaving for L2 this cycle is excluded so the new data is not lost behind the old write.
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    for (int i = 0; i < N_ENTRIES; i++)
      if (state_q[i] == WBB_VALID && addr_q[i] == evict_addr_i && !(tx && send_q == PW'(i))) begin
        coal_hit = 1'b1;
        coal_idx = PW'(i);
      end
  end
  assign evict_rdy_o = !full || coal_hit;
`else
  assign coal_hit = 1'b0;
  assign coal_idx = '0;
  assign evict_rdy_o = !full;
`endif
  assign push = evict_valid_i && evict_rdy_o;
  assign alloc = push && !coal_hit;
  assign wr_idx = coal_hit ? coal_idx : tail_q;
  always_comb begin
    state_d = state_q;
    if (alloc) state_d[tail_q] = WBB_VALID;
    if (tx) state_d[send_q] = WBB_SENT;
    if (ack) state_d[ack_q] = WBB_FREE;
    tail_d = tail_q + PW'(alloc);
    send_d = send_q + PW'(tx);
    ack_d = ack_q + PW'(ack);
    occ_d = occ_q + CW'(alloc) - CW'(ack);
    unsent_d = unsent_q + CW'(alloc) - CW'(tx);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= '{default: WBB_FREE};
      tail_q <= '0;
      send_q <= '0;
      ack_q <= '0;
      occ_q <= '0;
      unsent_q <= '0;
    end else begin
      state_q <= state_d;
      tail_q <= tail_d;
      send_q <= send_d;
      ack_q <= ack_d;
      occ_q <= occ_d;
      unsent_q <= unsent_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_q[wr_idx] <= evict_addr_i;
      line_q[wr_idx] <= evict_line_i;
    end
  end
  always_comb begin
    busy = '0;
    for (int i = 0; i < N_ENTRIES; i++) busy[i] = state_q[i] != WBB_FREE;
  end
  d1_wbb_fwd_lookup #(.N(N_ENTRIES), .AW(LINE_ADDR_W), .PW(PW)) u_lookup (
    .en_i(busy),
    .addr_i(addr_q),
    .lookup_addr_i(d0_lookup_addr_i),
    .tail_i(tail_q),
    .hit_o(fwd_hit),
    .idx_o(fwd_idx)
  );
  assign wbb_d0_fwd_o = d0_lookup_valid_i && fwd_hit;
  assign d0_fwd_line_o = line_q[fwd_idx];
  assign wbb_l2c_req_valid_o = unsent_q != '0;
  assign wbb_l2c_req_addr_o = addr_q[send_q];
  assign wbb_l2c_req_line_o = line_q[send_q];
  assign wbb_free_entries_o = wbb_free_entries_t'(CW'(N_ENTRIES) - occ_q);
  assign wbb_empty_o = occ_q == '0;
  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(wbb_l2c_transaction_ok_i && unsent_q == '0));
      assert (!(l2c_wbb_wr_ack_i && occ_q == unsent_q));
    end
  end
endmodule

// File: tb/tb_d1_wb_buffer.sv
// tb_d1_wb_buffer: directed self-checking bench for d1_wb_buffer
module tb_d1_wb_buffer;
  import memory_pkg::*;
  logic clk_i = 1'b0;
  logic rst_ni;
  logic evict_valid_i;
  logic [57:0] evict_addr_i;
  logic [511:0] evict_line_i;
  logic evict_rdy_o;
  logic d0_lookup_valid_i;
  logic [57:0] d0_lookup_addr_i;
  logic wbb_d0_fwd_o;
  logic [511:0] d0_fwd_line_o;
  logic wbb_l2c_req_valid_o;
  logic [57:0] wbb_l2c_req_addr_o;
  logic [511:0] wbb_l2c_req_line_o;
  logic wbb_l2c_transaction_ok_i;
  logic l2c_wbb_wr_ack_i;
  wbb_free_entries_t wbb_free_entries_o;
  logic wbb_empty_o;
  int checks = 0;
  int errors = 0;
  always #5 clk_i = ~clk_i;
  d1_wb_buffer dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .evict_valid_i(evict_valid_i),
    .evict_addr_i(evict_addr_i),
    .evict_line_i(evict_line_i),
    .evict_rdy_o(evict_rdy_o),
    .d0_lookup_valid_i(d0_lookup_valid_i),
    .d0_lookup_addr_i(d0_lookup_addr_i),
    .wbb_d0_fwd_o(wbb_d0_fwd_o),
    .d0_fwd_line_o(d0_fwd_line_o),
    .wbb_l2c_req_valid_o(wbb_l2c_req_valid_o),
    .wbb_l2c_req_addr_o(wbb_l2c_req_addr_o),
    .wbb_l2c_req_line_o(wbb_l2c_req_line_o),
    .wbb_l2c_transaction_ok_i(wbb_l2c_transaction_ok_i),
    .l2c_wbb_wr_ack_i(l2c_wbb_wr_ack_i),
    .wbb_free_entries_o(wbb_free_entries_o),
    .wbb_empty_o(wbb_empty_o)
  );
  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic push(input logic [57:0] a, input logic [511:0] d);
    evict_valid_i = 1'b1;
    evict_addr_i = a;
    evict_line_i = d;
    tick();
    evict_valid_i = 1'b0;
  endtask
  task automatic send();
    wbb_l2c_transaction_ok_i = 1'b1;
    tick();
    wbb_l2c_transaction_ok_i = 1'b0;
  endtask
  task automatic ack();
    l2c_wbb_wr_ack_i = 1'b1;
    tick();
    l2c_wbb_wr_ack_i = 1'b0;
  endtask
  task automatic lookup(input string tag, input logic [57:0] a, input logic hit, input logic [511:0] d);
    d0_lookup_valid_i = 1'b1;
    d0_lookup_addr_i = a;
    #1;
    check({tag, "_fwd"}, wbb_d0_fwd_o, hit);
    if (hit) check({tag, "_line"}, d0_fwd_line_o, d);
    d0_lookup_valid_i = 1'b0;
  endtask
  initial begin
    logic [57:0] exp_addr [4];
    rst_ni = 1'b0;
    evict_valid_i = 1'b0;
    evict_addr_i = '0;
    evict_line_i = '0;
    d0_lookup_valid_i = 1'b0;
    d0_lookup_addr_i = '0;
    wbb_l2c_transaction_ok_i = 1'b0;
    l2c_wbb_wr_ack_i = 1'b0;
    repeat (2) tick();
    rst_ni = 1'b1;
    tick();
    check("rst_rdy", evict_rdy_o, 1);
    check("rst_req", wbb_l2c_req_valid_o, 0);
    check("rst_fwd", wbb_d0_fwd_o, 0);
    check("rst_free", wbb_free_entries_o, 4);
    check("rst_empty", wbb_empty_o, 1);
    push(58'h10, 512'hA1);
    push(58'h20, 512'hB1);
    check("ab_free", wbb_free_entries_o, 2);
    check("ab_empty", wbb_empty_o, 0);
    check("ab_req", wbb_l2c_req_valid_o, 1);
    check("ab_addr0", wbb_l2c_req_addr_o, 58'h10);
    check("ab_line0", wbb_l2c_req_line_o, 512'hA1);
    send();
    check("ab_addr1", wbb_l2c_req_addr_o, 58'h20);
    check("ab_line1", wbb_l2c_req_line_o, 512'hB1);
    check("ab_free_sent", wbb_free_entries_o, 2);
    ack();
    check("ab_free_ack", wbb_free_entries_o, 3);
    send();
    check("ab_req_idle", wbb_l2c_req_valid_o, 0);
    ack();
    check("ab_empty_end", wbb_empty_o, 1);
    for (int i = 0; i < 4; i++) push(58'h30 + 58'(i), 512'h300 + 512'(i));
    check("full_free", wbb_free_entries_o, 0);
    check("full_rdy", evict_rdy_o, 0);
    send();
    evict_valid_i = 1'b1;
    evict_addr_i = 58'h40;
    evict_line_i = 512'h400;
    l2c_wbb_wr_ack_i = 1'b1;
    check("full_ack_rdy", evict_rdy_o, 0);
    tick();
    l2c_wbb_wr_ack_i = 1'b0;
    check("refused_free", wbb_free_entries_o, 1);
    check("refused_rdy", evict_rdy_o, 1);
    tick();
    evict_valid_i = 1'b0;
    check("accepted_free", wbb_free_entries_o, 0);
    exp_addr = '{58'h31, 58'h32, 58'h33, 58'h40};
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_addr%0d", i), wbb_l2c_req_addr_o, exp_addr[i]);
      send();
      ack();
    end
    check("drain_empty", wbb_empty_o, 1);
    push(58'h10, 512'h111);
    push(58'h10, 512'h222);
    lookup("dup", 58'h10, 1, 512'h222);
    check("dup_req_kept", wbb_l2c_req_valid_o, 1);
    lookup("miss", 58'h99, 0, '0);
    d0_lookup_addr_i = 58'h10;
    #1;
    check("novalid_fwd", wbb_d0_fwd_o, 0);
    send();
    lookup("sent1", 58'h10, 1, 512'h222);
    send();
    lookup("sent2", 58'h10, 1, 512'h222);
    check("sent2_req", wbb_l2c_req_valid_o, 0);
    check("sent2_free", wbb_free_entries_o, 2);
    ack();
    lookup("ack1", 58'h10, 1, 512'h222);
    ack();
    lookup("ack2", 58'h10, 0, '0);
    check("ack2_empty", wbb_empty_o, 1);
    push(58'h50, 512'h500);
    push(58'h60, 512'h600);
    send();
    evict_valid_i = 1'b1;
    evict_addr_i = 58'h70;
    evict_line_i = 512'h700;
    wbb_l2c_transaction_ok_i = 1'b1;
    l2c_wbb_wr_ack_i = 1'b1;
    tick();
    evict_valid_i = 1'b0;
    wbb_l2c_transaction_ok_i = 1'b0;
    l2c_wbb_wr_ack_i = 1'b0;
    check("sim_free", wbb_free_entries_o, 2);
    check("sim_req", wbb_l2c_req_valid_o, 1);
    check("sim_addr", wbb_l2c_req_addr_o, 58'h70);
    check("sim_line", wbb_l2c_req_line_o, 512'h700);
    lookup("sim_acked", 58'h50, 0, '0);
    lookup("sim_sent", 58'h60, 1, 512'h600);
    send();
    check("sim_req_idle", wbb_l2c_req_valid_o, 0);
    ack();
    ack();
    check("sim_empty", wbb_empty_o, 1);
`ifdef D1_WBB_COALESCE_EN
    for (int i = 0; i < 4; i++) push(58'h80 + 58'(i), 512'h800 + 512'(i));
    evict_addr_i = 58'h82;
    #1;
    check("coal_rdy", evict_rdy_o, 1);
    push(58'h82, 512'hC0C0);
    check("coal_free", wbb_free_entries_o, 0);
    lookup("coal", 58'h82, 1, 512'hC0C0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/d1_wb_buffer.md
Name: d1_wb_buffer

Overview:
- Write-back buffer (WBB) for the L1 D-cache, stage d1.
- Accepts dirty-line evictions from d1 and issues them as L2 write requests through the MSHR/WBB L2 request arbiter.
- Holds each line until L2 acknowledges the write, so that d0 can forward it on a miss.
- Produces wbb_l2c_req_valid, wbb_free_entries and wbb_d0_fwd for the arbiter.

Parameters:
- N_ENTRIES, 4: buffer depth. Power of two, at least 2.
- LINE_ADDR_W, 58: width of a line address (byte address without the offset bits).
- LINE_W, 512: cache line width in bits.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- evict_valid_i  in  1  dirty eviction push request
- evict_addr_i  in  LINE_ADDR_W  evicted line address
- evict_line_i  in  LINE_W  evicted line data
- evict_rdy_o  out  1  buffer can accept a push
- d0_lookup_valid_i  in  1  d0 miss lookup valid
- d0_lookup_addr_i  in  LINE_ADDR_W  d0 lookup line address
- wbb_d0_fwd_o  out  1  lookup hit; the storage read port is used for forwarding this cycle
- d0_fwd_line_o  out  LINE_W  forwarded line data
- wbb_l2c_req_valid_o  out  1  oldest unsent entry pending
- wbb_l2c_req_addr_o  out  LINE_ADDR_W  address of the oldest unsent entry
- wbb_l2c_req_line_o  out  LINE_W  data of the oldest unsent entry
- wbb_l2c_transaction_ok_i  in  1  arbiter: the WBB request was accepted by L2C this cycle
- l2c_wbb_wr_ack_i  in  1  L2C write completed; acks arrive in order
- wbb_free_entries_o  out  wbb_free_entries_t  N_ENTRIES minus occupied entries
- wbb_empty_o  out  1  no occupied entries

Behaviour:
- Storage is a circular array; each entry has a state of type wbb_entry_state_e: WBB_FREE, WBB_VALID (not yet sent) or WBB_SENT (awaiting ack).
- Pointers (log2(N_ENTRIES) bits each, natural wrap):
  - tail_q: next entry to allocate.
  - send_q: oldest WBB_VALID entry.
  - ack_q: oldest WBB_SENT entry.
- Counters:
  - occ_q in [0..N_ENTRIES].
  - unsent_q in [0..occ_q].
- Reset: all entries WBB_FREE; all pointers and counters 0. Consequently evict_rdy_o=1, wbb_l2c_req_valid_o=0, wbb_d0_fwd_o=0, wbb_free_entries_o=N_ENTRIES, wbb_empty_o=1. Line and address storage is not reset.
- evict_rdy_o = (occ_q != N_ENTRIES).
  - Evaluated from registered state only.
  - A push when full is refused even if an ack arrives in the same cycle.
- Push (evict_valid_i && evict_rdy_o): write the line at tail_q, mark it WBB_VALID, increment tail_q, occ_q and unsent_q. The entry is visible from the next cycle.
- Request outputs:
  - wbb_l2c_req_valid_o = (unsent_q != 0).
  - Address and data come from send_q, combinationally.
  - The request stays asserted until accepted; it is never withdrawn because of forwarding.
- wbb_l2c_transaction_ok_i with unsent_q != 0: send_q entry becomes WBB_SENT; increment send_q; decrement unsent_q.
- l2c_wbb_wr_ack_i with a WBB_SENT entry present: ack_q entry becomes WBB_FREE; increment ack_q; decrement occ_q.
- Spurious transaction_ok or ack (nothing to act on) is ignored, and a simulation assertion fires.
- Forwarding lookup:
  - Compare d0_lookup_addr_i against every non-FREE entry, combinationally.
  - On multiple matches, the youngest entry (closest behind tail_q) wins.
  - wbb_d0_fwd_o = d0_lookup_valid_i && hit; d0_fwd_line_o = winning entry data.
  - The lookup sees registered state only; a push in the same cycle is not bypassed.
  - Forwarding does not change any entry state.
  - While wbb_d0_fwd_o=1 the single read port is busy, so the arbiter masks the WBB request.
- Simultaneous push, transaction_ok and ack in one cycle: all three apply. occ_q and unsent_q are updated with net deltas (for example, push plus ack leaves occ_q unchanged).
- wbb_free_entries_o = N_ENTRIES - occ_q, registered-derived.
- wbb_empty_o = (occ_q == 0).
- Reset mid-operation: all entries drop to WBB_FREE immediately, and in-flight L2 writes are forgotten. Acks after reset are spurious and are ignored.

Optional Feature:
- Macro: D1_WBB_COALESCE_EN.
- Defined: a push whose address matches an entry in WBB_VALID state overwrites that entry's data in place. Pointers and counters do not change, and the push is accepted even when the buffer is full. A match on a WBB_SENT entry still allocates a new entry.
- Undefined: every push allocates a new entry.

Decomposition:
- memory_pkg additions:
  - WBB_N_ENTRIES.
  - wbb_free_entries_t (clog2(WBB_N_ENTRIES+1) bits).
  - wbb_entry_state_e.
  - wbb_entry_t (state, address, line).
- Sub-module d1_wbb_fwd_lookup: N-way address compare with youngest-match priority relative to tail_q. Outputs hit and the winning index.

Test Plan:
- Reset, then push lines A=0x10 and B=0x20 -> wbb_free_entries_o=2, wbb_l2c_req_valid_o=1 with addr 0x10; after transaction_ok, addr 0x20.
- Fill 4 entries and hold evict_valid_i with ack in the same cycle -> evict_rdy_o=0 and the push is refused; next cycle evict_rdy_o=1 and the push is accepted; free entries go 0->1->0.
- Push A twice with different data (macro off), then look up A -> wbb_d0_fwd_o=1 and d0_fwd_line_o equals the second (youngest) data.
- Send A (now WBB_SENT), then look up A -> hit, data forwarded, state unchanged; ack -> entry freed; a later lookup of A misses.
- Push, transaction_ok and ack in the same cycle with occ=2 -> occ stays 2, unsent count unchanged, pointers advance by one each.
- D1_WBB_COALESCE_EN defined, buffer full, push to a WBB_VALID address -> accepted, data overwritten, wbb_free_entries_o stays 0.
